// File: rtl/ex_mem_if.sv
// EX/MEM pipeline bus: EX-stage results going in, registered MEM-stage view coming out.
// The EX stage uses the master modport and the pipeline register uses the slave modport.
interface ex_mem_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    logic              inValid;
    logic [DATA_W-1:0] inAluResult;
    logic              inZero;
    logic [DATA_W-1:0] inStoreData;
    logic [REG_W-1:0]  inWriteReg;
    logic [DATA_W-1:0] inBranchTarget;
    logic              inRegWrite;
    logic              inMemRead;
    logic              inMemWrite;
    logic              inMemtoReg;
    logic              inBranch;
    logic [1:0]        inMemSize;

    logic              outValid;
    logic [DATA_W-1:0] outAluResult;
    logic [DATA_W-1:0] outStoreData;
    logic [3:0]        outByteEnable;
    logic [REG_W-1:0]  outWriteReg;
    logic              outRegWrite;
    logic              outMemRead;
    logic              outMemWrite;
    logic              outMemtoReg;
    logic              outBranchTaken;
    logic [DATA_W-1:0] outBranchTarget;
    logic              outMisaligned;
    logic [15:0]       outStallCount;

    modport master (
        output inValid, inAluResult, inZero, inStoreData, inWriteReg, inBranchTarget,
               inRegWrite, inMemRead, inMemWrite, inMemtoReg, inBranch, inMemSize,
        input  outValid, outAluResult, outStoreData, outByteEnable, outWriteReg,
               outRegWrite, outMemRead, outMemWrite, outMemtoReg, outBranchTaken,
               outBranchTarget, outMisaligned, outStallCount
    );

    modport slave (
        input  inValid, inAluResult, inZero, inStoreData, inWriteReg, inBranchTarget,
               inRegWrite, inMemRead, inMemWrite, inMemtoReg, inBranch, inMemSize,
        output outValid, outAluResult, outStoreData, outByteEnable, outWriteReg,
               outRegWrite, outMemRead, outMemWrite, outMemtoReg, outBranchTaken,
               outBranchTarget, outMisaligned, outStallCount
    );
endinterface

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with flush/stall control, byte-lane generation,
// store-data replication, misalignment suppression and a saturating stall counter.
module ex_mem_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic    clk,
    input  logic    reset_n,
    input  logic    stall,
    input  logic    flush,
    ex_mem_if.slave bus
);
    logic              valid_q,      valid_d;
    logic [DATA_W-1:0] alu_q,        alu_d;
    logic [DATA_W-1:0] store_q,      store_d;
    logic [3:0]        be_q,         be_d;
    logic [REG_W-1:0]  wreg_q,       wreg_d;
    logic              regwrite_q,   regwrite_d;
    logic              memread_q,    memread_d;
    logic              memwrite_q,   memwrite_d;
    logic              memtoreg_q,   memtoreg_d;
    logic              br_taken_q,   br_taken_d;
    logic [DATA_W-1:0] br_target_q,  br_target_d;
    logic              misaligned_q, misaligned_d;
    logic [15:0]       stall_cnt_q,  stall_cnt_d;

    logic              mem_access;
    logic [1:0]        addr_lo;
    logic              mis_raw;
    logic              misaligned;
    logic [3:0]        be_raw;
    logic [DATA_W-1:0] byte_rep;
    logic [DATA_W-1:0] half_rep;
    logic [DATA_W-1:0] store_fmt;

    // Sub-word stores are replicated across every lane so memory can pick by byte enable.
    for (genvar gi = 0; gi < DATA_W / 8; gi++) begin : g_byte_rep
        assign byte_rep[gi*8 +: 8] = bus.inStoreData[7:0];
    end
    for (genvar gi = 0; gi < DATA_W / 16; gi++) begin : g_half_rep
        assign half_rep[gi*16 +: 16] = bus.inStoreData[15:0];
    end

    always_comb begin
        mem_access = bus.inMemRead | bus.inMemWrite;
        addr_lo    = bus.inAluResult[1:0];
        case (bus.inMemSize)
            2'b00: begin
                mis_raw = 1'b0;
                be_raw  = 4'b1000 >> addr_lo;
            end
            2'b01: begin
                mis_raw = addr_lo[0];
                be_raw  = addr_lo[1] ? 4'b0011 : 4'b1100;
            end
            default: begin
                mis_raw = |addr_lo;
                be_raw  = 4'b1111;
            end
        endcase
        misaligned = mem_access & mis_raw;

        if (bus.inMemWrite && bus.inMemSize == 2'b00)
            store_fmt = byte_rep;
        else if (bus.inMemWrite && bus.inMemSize == 2'b01)
            store_fmt = half_rep;
        else
            store_fmt = bus.inStoreData;
    end

    always_comb begin
        valid_d      = valid_q;
        alu_d        = alu_q;
        store_d      = store_q;
        be_d         = be_q;
        wreg_d       = wreg_q;
        regwrite_d   = regwrite_q;
        memread_d    = memread_q;
        memwrite_d   = memwrite_q;
        memtoreg_d   = memtoreg_q;
        br_taken_d   = br_taken_q;
        br_target_d  = br_target_q;
        misaligned_d = misaligned_q;
        stall_cnt_d  = stall_cnt_q;

        if (flush || (!stall && !bus.inValid)) begin
            // Bubble: everything but the stall counter clears.
            valid_d      = 1'b0;
            alu_d        = '0;
            store_d      = '0;
            be_d         = '0;
            wreg_d       = '0;
            regwrite_d   = 1'b0;
            memread_d    = 1'b0;
            memwrite_d   = 1'b0;
            memtoreg_d   = 1'b0;
            br_taken_d   = 1'b0;
            br_target_d  = '0;
            misaligned_d = 1'b0;
        end else if (stall) begin
            if (stall_cnt_q != 16'hFFFF)
                stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            valid_d      = 1'b1;
            alu_d        = bus.inAluResult;
            store_d      = store_fmt;
            be_d         = (mem_access && !misaligned) ? be_raw : 4'b0000;
            wreg_d       = bus.inWriteReg;
            regwrite_d   = bus.inRegWrite & ~misaligned;
            memread_d    = bus.inMemRead & ~misaligned;
            memwrite_d   = bus.inMemWrite & ~misaligned;
            memtoreg_d   = bus.inMemtoReg;
            br_taken_d   = bus.inBranch & bus.inZero & ~misaligned;
            br_target_d  = bus.inBranchTarget;
            misaligned_d = misaligned;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q      <= 1'b0;
            alu_q        <= '0;
            store_q      <= '0;
            be_q         <= '0;
            wreg_q       <= '0;
            regwrite_q   <= 1'b0;
            memread_q    <= 1'b0;
            memwrite_q   <= 1'b0;
            memtoreg_q   <= 1'b0;
            br_taken_q   <= 1'b0;
            br_target_q  <= '0;
            misaligned_q <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            valid_q      <= valid_d;
            alu_q        <= alu_d;
            store_q      <= store_d;
            be_q         <= be_d;
            wreg_q       <= wreg_d;
            regwrite_q   <= regwrite_d;
            memread_q    <= memread_d;
            memwrite_q   <= memwrite_d;
            memtoreg_q   <= memtoreg_d;
            br_taken_q   <= br_taken_d;
            br_target_q  <= br_target_d;
            misaligned_q <= misaligned_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign bus.outValid        = valid_q;
    assign bus.outAluResult    = alu_q;
    assign bus.outStoreData    = store_q;
    assign bus.outByteEnable   = be_q;
    assign bus.outWriteReg     = wreg_q;
    assign bus.outRegWrite     = regwrite_q;
    assign bus.outMemRead      = memread_q;
    assign bus.outMemWrite     = memwrite_q;
    assign bus.outMemtoReg     = memtoreg_q;
    assign bus.outBranchTaken  = br_taken_q;
    assign bus.outBranchTarget = br_target_q;
    assign bus.outMisaligned   = misaligned_q;
    assign bus.outStallCount   = stall_cnt_q;
endmodule

// File: tb/tb_ex_mem_reg.sv
// Randomized and directed bench for ex_mem_reg against a transaction-level reference model.
module tb_ex_mem_reg;
    typedef struct packed {
        logic        valid;
        logic [31:0] alu;
        logic        zero;
        logic [31:0] sd;
        logic [4:0]  wr;
        logic [31:0] bt;
        logic        rw, mr, mw, m2r, br;
        logic [1:0]  size;
    } in_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] alu;
        logic [31:0] sd;
        logic [3:0]  be;
        logic [4:0]  wr;
        logic        rw, mr, mw, m2r, taken;
        logic [31:0] bt;
        logic        mis;
        logic [15:0] cnt;
    } out_t;

    logic clk = 1'b0;
    logic reset_n;
    logic stall;
    logic flush;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_txn = 0;
    out_t exp_o;

    ex_mem_if #(.DATA_W(32), .REG_W(5)) bus ();

    ex_mem_reg #(.DATA_W(32), .REG_W(5)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .stall   (stall),
        .flush   (flush),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: what the MEM stage should see after one edge, from the rules of the stage.
    function automatic out_t model(input out_t cur, input in_t x, input logic st, input logic fl);
        out_t n;
        int   a;
        int   nbytes;
        logic mem;
        logic mis;
        n = '0;
        n.cnt = cur.cnt;
        if (fl) return n;
        if (st) begin
            n = cur;
            if (cur.cnt != 16'hFFFF) n.cnt = cur.cnt + 16'd1;
            return n;
        end
        if (!x.valid) return n;
        a      = int'(x.alu[1:0]);
        nbytes = (x.size == 2'd0) ? 1 : (x.size == 2'd1) ? 2 : 4;
        mem    = x.mr | x.mw;
        mis    = mem && ((a % nbytes) != 0);
        n.valid = 1'b1;
        n.alu   = x.alu;
        n.wr    = x.wr;
        n.bt    = x.bt;
        n.m2r   = x.m2r;
        n.mis   = mis;
        n.sd    = x.sd;
        if (x.mw && x.size == 2'd0) n.sd = 32'(x.sd[7:0]) * 32'h0101_0101;
        if (x.mw && x.size == 2'd1) n.sd = 32'(x.sd[15:0]) * 32'h0001_0001;
        if (!mis) begin
            n.rw    = x.rw;
            n.mr    = x.mr;
            n.mw    = x.mw;
            n.taken = x.br & x.zero;
            if (mem)
                for (int lane = a; lane < a + nbytes; lane++) n.be[3 - lane] = 1'b1;
        end
        return n;
    endfunction

    function automatic out_t get_dut();
        out_t o;
        o.valid = bus.outValid;
        o.alu   = bus.outAluResult;
        o.sd    = bus.outStoreData;
        o.be    = bus.outByteEnable;
        o.wr    = bus.outWriteReg;
        o.rw    = bus.outRegWrite;
        o.mr    = bus.outMemRead;
        o.mw    = bus.outMemWrite;
        o.m2r   = bus.outMemtoReg;
        o.taken = bus.outBranchTaken;
        o.bt    = bus.outBranchTarget;
        o.mis   = bus.outMisaligned;
        o.cnt   = bus.outStallCount;
        return o;
    endfunction

    task automatic compare_all(input string ph);
        out_t o;
        o = get_dut();
        chk({ph, ".valid"}, 64'(o.valid), 64'(exp_o.valid));
        chk({ph, ".alu"},   64'(o.alu),   64'(exp_o.alu));
        chk({ph, ".sd"},    64'(o.sd),    64'(exp_o.sd));
        chk({ph, ".be"},    64'(o.be),    64'(exp_o.be));
        chk({ph, ".wr"},    64'(o.wr),    64'(exp_o.wr));
        chk({ph, ".rw"},    64'(o.rw),    64'(exp_o.rw));
        chk({ph, ".mr"},    64'(o.mr),    64'(exp_o.mr));
        chk({ph, ".mw"},    64'(o.mw),    64'(exp_o.mw));
        chk({ph, ".m2r"},   64'(o.m2r),   64'(exp_o.m2r));
        chk({ph, ".taken"}, 64'(o.taken), 64'(exp_o.taken));
        chk({ph, ".bt"},    64'(o.bt),    64'(exp_o.bt));
        chk({ph, ".mis"},   64'(o.mis),   64'(exp_o.mis));
        chk({ph, ".cnt"},   64'(o.cnt),   64'(exp_o.cnt));
    endtask

    task automatic set_inputs(input in_t x, input logic st, input logic fl);
        bus.inValid        = x.valid;
        bus.inAluResult    = x.alu;
        bus.inZero         = x.zero;
        bus.inStoreData    = x.sd;
        bus.inWriteReg     = x.wr;
        bus.inBranchTarget = x.bt;
        bus.inRegWrite     = x.rw;
        bus.inMemRead      = x.mr;
        bus.inMemWrite     = x.mw;
        bus.inMemtoReg     = x.m2r;
        bus.inBranch       = x.br;
        bus.inMemSize      = x.size;
        stall              = st;
        flush              = fl;
    endtask

    // Called just after a falling edge; returns after the next falling edge with outputs checked.
    task automatic drive(input string ph, input in_t x, input logic st, input logic fl);
        set_inputs(x, st, fl);
        exp_o = model(exp_o, x, st, fl);
        @(negedge clk);
        n_txn++;
        $display("txn %0d %s st=%0b fl=%0b v=%0b alu=%h size=%0d mr=%0b mw=%0b",
                 n_txn, ph, st, fl, x.valid, x.alu, x.size, x.mr, x.mw);
        compare_all(ph);
    endtask

    function automatic in_t rand_in();
        in_t x;
        x.valid = ($urandom_range(3) != 0);
        x.alu   = $urandom;
        x.zero  = 1'($urandom_range(1));
        x.sd    = $urandom;
        x.wr    = 5'($urandom_range(31));
        x.bt    = $urandom;
        x.rw    = 1'($urandom_range(1));
        x.mr    = 1'($urandom_range(1));
        x.mw    = 1'($urandom_range(1));
        x.m2r   = 1'($urandom_range(1));
        x.br    = 1'($urandom_range(1));
        x.size  = 2'($urandom_range(3));
        return x;
    endfunction

    initial begin
        in_t  x;
        logic st, fl;
        reset_n = 1'b0;
        exp_o   = '0;
        set_inputs(in_t'('0), 1'b0, 1'b0);
        #3;
        compare_all("reset");
        @(negedge clk);
        reset_n = 1'b1;

        x = '0; x.valid = 1'b1; x.alu = 32'h1004; x.sd = 32'hAABB_CCDD; x.mw = 1'b1; x.size = 2'd2;
        drive("word_store", x, 1'b0, 1'b0);
        chk("word_store.be_const", 64'(bus.outByteEnable), 64'h0F);
        chk("word_store.sd_const", 64'(bus.outStoreData), 64'hAABB_CCDD);

        x = '0; x.valid = 1'b1; x.alu = 32'h1002; x.sd = 32'h0000_00EE; x.mw = 1'b1; x.size = 2'd0;
        drive("byte_store", x, 1'b0, 1'b0);
        chk("byte_store.be_const", 64'(bus.outByteEnable), 64'h2);
        chk("byte_store.sd_const", 64'(bus.outStoreData), 64'hEEEE_EEEE);

        x = '0; x.valid = 1'b1; x.alu = 32'h1001; x.mr = 1'b1; x.rw = 1'b1; x.size = 2'd1;
        drive("half_mis", x, 1'b0, 1'b0);
        chk("half_mis.mis_const", 64'(bus.outMisaligned), 64'h1);
        chk("half_mis.rw_const", 64'(bus.outRegWrite), 64'h0);

        x = '0; x.valid = 1'b1; x.br = 1'b1; x.zero = 1'b1; x.bt = 32'h40;
        drive("branch", x, 1'b0, 1'b0);
        chk("branch.taken_const", 64'(bus.outBranchTaken), 64'h1);
        drive("branch_fl_st", x, 1'b1, 1'b1);
        chk("branch_fl_st.cnt_const", 64'(bus.outStallCount), 64'h0);

        x = '0; x.valid = 1'b1; x.alu = 32'h5; x.wr = 5'd8; x.rw = 1'b1;
        drive("addu", x, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive("hold", rand_in(), 1'b1, 1'b0);
        chk("hold.alu_const", 64'(bus.outAluResult), 64'h5);
        chk("hold.wr_const", 64'(bus.outWriteReg), 64'h8);
        chk("hold.cnt_const", 64'(bus.outStallCount), 64'h3);

        // Asynchronous reset mid-stall, checked before the following rising edge.
        set_inputs(rand_in(), 1'b1, 1'b0);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        exp_o   = '0;
        #1;
        compare_all("async_rst");
        @(negedge clk);
        reset_n = 1'b1;
        x = '0; x.valid = 1'b1; x.alu = 32'h2000; x.mr = 1'b1; x.size = 2'd2; x.wr = 5'd3;
        drive("post_rst", x, 1'b0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            fl = ($urandom_range(7) == 0);
            st = ($urandom_range(3) == 0);
            drive("rand", rand_in(), st, fl);
        end

        // Drive the counter into saturation.
        set_inputs(rand_in(), 1'b1, 1'b0);
        for (int i = 0; i < 65540; i++) begin
            exp_o = model(exp_o, rand_in(), 1'b1, 1'b0);
            @(negedge clk);
        end
        compare_all("sat");
        chk("sat.cnt_const", 64'(bus.outStallCount), 64'hFFFF);
        drive("sat_more", rand_in(), 1'b1, 1'b0);
        drive("sat_flush", rand_in(), 1'b0, 1'b1);
        x = rand_in(); x.valid = 1'b1;
        drive("sat_load", x, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/ex_mem_reg.md
EX_MEM_REG -- requirements
Module: ex_mem_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width of ALU result, store data and branch target.
REQ-002 SHALL have parameter REG_W, default 5, destination register index width.
REQ-003 SHALL have a single clock and an asynchronous, active-low reset: clk, input, 1, rising-edge clock for all state.
REQ-004 SHALL have reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have stall, input, 1, hold all registered outputs this cycle.
REQ-006 SHALL have flush, input, 1, load a bubble this cycle.
REQ-007 SHALL have inValid, input, 1, EX stage holds a real instruction.
REQ-008 SHALL have inAluResult, input, DATA_W, ALU result or memory address.
REQ-009 SHALL have inZero, input, 1, ALU branch condition (already BEQ/BNE-resolved).
REQ-010 SHALL have inStoreData, input, DATA_W, forwarded rt value for stores.
REQ-011 SHALL have inWriteReg, input, REG_W, destination register.
REQ-012 SHALL have inBranchTarget, input, DATA_W, computed branch PC.
REQ-013 SHALL have inRegWrite, inMemRead, inMemWrite, inMemtoReg, inBranch, inputs, 1 each, EX-stage control bits.
REQ-014 SHALL have inMemSize, input, 2, 00 byte, 01 half, 10 word, 11 reserved (treated as word).
REQ-015 SHALL have registered outputs outValid (1), outAluResult (DATA_W), outStoreData (DATA_W), outByteEnable (4), outWriteReg (REG_W), outRegWrite, outMemRead, outMemWrite, outMemtoReg (1 each).
REQ-016 SHALL have registered outputs outBranchTaken (1), outBranchTarget (DATA_W), outMisaligned (1), outStallCount (16, saturating held-cycle counter).

Function
REQ-017 SHALL update on rising clk; priority per cycle: flush > stall > load.
REQ-018 Load: all out* SHALL take values derived from in* with one-cycle latency.
REQ-019 Flush: outValid, all control outputs, outBranchTaken, outMisaligned, outByteEnable SHALL become 0; data fields SHALL become 0.
REQ-020 Stall without flush: every output except outStallCount SHALL hold its value.
REQ-021 outStallCount SHALL increment by 1 each cycle stall=1 and flush=0, saturating at 16'hFFFF; SHALL never wrap.
REQ-022 A loaded instruction with inValid=0 SHALL be captured as a bubble (same as REQ-019).
REQ-023 Address low bits a=inAluResult[1:0]; misaligned = (size half and a[0]=1) or (size word/reserved and a!=0), evaluated only when inMemRead or inMemWrite.
REQ-024 Byte enables (big-endian lane 0 = bits 31:24): byte -> 4'b1000>>a; half -> a[1]=0 ? 4'b1100 : 4'b0011; word -> 4'b1111; SHALL be 0 when no memory access or misaligned.
REQ-025 outStoreData SHALL be the low byte replicated x4 for byte stores, low half replicated x2 for half stores, unmodified otherwise.
REQ-026 Misaligned access: outMisaligned=1, outMemRead=outMemWrite=outRegWrite=0, outBranchTaken=0, outValid=1, remaining fields loaded normally; outMisaligned SHALL clear on the next load or flush.
REQ-027 outBranchTaken SHALL equal inValid & inBranch & inZero at load; outBranchTarget SHALL always load inBranchTarget.
REQ-028 outAluResult and outWriteReg SHALL pass unmodified on load.

Reset
REQ-029 reset_n=0 SHALL immediately (asynchronously) force every output to 0, including outStallCount.
REQ-030 Reset asserted mid-stall SHALL clear held contents; first edge after release SHALL perform a normal load/flush/stall decision.

Verification
REQ-031 Load word store addr 0x1004, data 0xAABBCCDD -> next cycle outByteEnable=1111, outStoreData=0xAABBCCDD, outMemWrite=1, outMisaligned=0.
REQ-032 Byte store addr 0x1002, data 0x000000EE -> outByteEnable=0010, outStoreData=0xEEEEEEEE.
REQ-033 Half load addr 0x1001 with inRegWrite=1 -> outMisaligned=1, outMemRead=0, outRegWrite=0, outByteEnable=0000.
REQ-034 Branch inValid=1, inBranch=1, inZero=1, target 0x40 -> outBranchTaken=1, outBranchTarget=0x40; same with flush=1 and stall=1 together -> outBranchTaken=0, outValid=0, outStallCount unchanged.
REQ-035 Stall 3 cycles after loading ADDU result 0x5 to r8 -> outputs hold 0x5/r8, outStallCount=3; preload count to 0xFFFF -> stays 0xFFFF.
REQ-036 Assert reset_n=0 between clock edges during stall -> all outputs 0 before the next edge.
